// File: rtl/lcd_cmd_issuer_if.sv
// Command handshake bundle between the host-side command source, the issuer
// and the image display controller.
interface lcd_cmd_issuer_if;
  localparam int unsigned CMD_W = 4;

  // Host push side
  logic [CMD_W-1:0] in_cmd;
  logic             in_valid;
  logic             in_ready;

  // Controller side
  logic             busy;
  logic             done;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;

  // Issuer view: consumes host pushes and controller status, drives commands.
  modport master (
    input  in_cmd,
    input  in_valid,
    output in_ready,
    input  busy,
    input  done,
    output cmd,
    output cmd_valid
  );

  // Environment view: host plus controller.
  modport slave (
    output in_cmd,
    output in_valid,
    input  in_ready,
    output busy,
    output done,
    input  cmd,
    input  cmd_valid
  );
endinterface

// File: rtl/lcd_cmd_issuer.sv
// Buffers host commands in a FIFO and issues them one at a time to the display
// controller, pacing on busy and locking after a Write. Option: CMD_FILTER_EN.
module lcd_cmd_issuer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  lcd_cmd_issuer_if.master  bus,
  output logic [AW:0]       fifo_level,
  output logic [7:0]        issued_cnt,
  output logic              seq_done,
  output logic [3:0]        err_cnt
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 8;
  localparam logic [CW-1:0] CMD_WRITE  = CW'(0);
  localparam logic [IW-1:0] ISSUED_MAX = IW'(255);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO,
    WAIT_DONE,
    FIN
  } state_e;

  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  state_e        state_q, state_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          lock_q, lock_d;
  logic          seq_done_q, seq_done_d;
  logic [IW-1:0] issued_q, issued_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          illegal;
  logic [CW-1:0] head;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == LW'(0));
  assign head  = mem_q[rd_ptr_q];

  // Readiness ignores a same-cycle pop so a full FIFO never accepts.
  assign bus.in_ready = !full && !lock_q;
  assign push         = bus.in_valid && !full && !lock_q;

`ifdef CMD_FILTER_EN
  localparam logic [CW-1:0] CMD_ILLEGAL_MIN = CW'(12);
  localparam logic [3:0]    ERR_MAX         = 4'hF;

  logic [3:0] err_q, err_d;

  assign illegal = (head >= CMD_ILLEGAL_MIN);

  // Count discarded codes; the discard itself is the FSM's pop.
  always_comb begin
    err_d = err_q;
    if (pop && illegal && (err_q != ERR_MAX)) begin
      err_d = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 4'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign illegal = 1'b0;
  assign err_cnt = 4'd0;
`endif

  // FIFO pointer and occupancy update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_cmd;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Issue sequencing
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    lock_d      = lock_q;
    seq_done_d  = seq_done_q;
    issued_d    = issued_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && !bus.busy) begin
          pop = 1'b1;
          if (!illegal) begin
            cmd_d       = head;
            cmd_valid_d = 1'b1;
            if (issued_q != ISSUED_MAX) begin
              issued_d = issued_q + IW'(1);
            end
            if (head == CMD_WRITE) begin
              lock_d = 1'b1;
            end
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        // cmd_q still holds the command just issued.
        if (bus.busy) begin
          state_d = (cmd_q == CMD_WRITE) ? WAIT_DONE : WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.busy) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.done) begin
          seq_done_d = 1'b1;
          state_d    = FIN;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      lock_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      issued_q    <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      lock_q      <= lock_d;
      seq_done_q  <= seq_done_d;
      issued_q    <= issued_d;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign fifo_level    = level_q;
  assign issued_cnt    = issued_q;
  assign seq_done      = seq_done_q;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Bench for lcd_cmd_issuer: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model and a small controller emulation.
module tb_lcd_cmd_issuer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  localparam int P_IDLE = 0;
  localparam int P_HI   = 1;
  localparam int P_LO   = 2;
  localparam int P_DONE = 3;
  localparam int P_FIN  = 4;

`ifdef CMD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW:0]   fifo_level;
  logic [7:0]    issued_cnt;
  logic          seq_done;
  logic [3:0]    err_cnt;

  lcd_cmd_issuer_if bus_if ();

  lcd_cmd_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .fifo_level (fifo_level),
    .issued_cnt (issued_cnt),
    .seq_done   (seq_done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [3:0] q[$];
  int         m_phase;
  bit         m_lock;
  bit         m_valid;
  bit         m_seq;
  logic [3:0] m_cmd;
  int         m_issued;
  int         m_err;

  // Controller emulation state
  int busy_left;
  int write_left;
  int op_max;
  bit busy_force;
  bit busy_noise;
  bit done_noise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase    = P_IDLE;
    m_lock     = 1'b0;
    m_valid    = 1'b0;
    m_seq      = 1'b0;
    m_cmd      = 4'd0;
    m_issued   = 0;
    m_err      = 0;
    busy_left  = 0;
    write_left = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic [3:0] c;
    bit         acc;
    acc     = bus_if.in_valid && (q.size() < int'(DEPTH)) && !m_lock;
    m_valid = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (q.size() > 0 && !bus_if.busy) begin
          c = q.pop_front();
          if (FILT && c >= 4'd12) begin
            if (m_err < 15) m_err++;
          end else begin
            m_cmd   = c;
            m_valid = 1'b1;
            if (m_issued < 255) m_issued++;
            if (c == 4'd0) m_lock = 1'b1;
            m_phase = P_HI;
          end
        end
      end
      P_HI:   if (bus_if.busy) m_phase = (m_cmd == 4'd0) ? P_DONE : P_LO;
      P_LO:   if (!bus_if.busy) m_phase = P_IDLE;
      P_DONE: if (bus_if.done) begin m_seq = 1'b1; m_phase = P_FIN; end
      default: ;
    endcase
    if (acc) q.push_back(bus_if.in_cmd);
  endtask

  // Controller reacts to the predicted issue: short OP busy, or long Write with done.
  task automatic ctrl_update();
    if (m_valid && m_cmd == 4'd0) write_left = 66;
    else if (write_left > 0) write_left--;
    if (m_valid && m_cmd != 4'd0) busy_left = int'($urandom_range(1, op_max));
    else if (busy_left > 0) busy_left--;
    bus_if.busy = busy_force || (busy_left > 0) || (write_left > 0) ||
                  (busy_noise && $urandom_range(0, 3) == 0);
    bus_if.done = (write_left == 1) || (done_noise && !m_lock && $urandom_range(0, 7) == 0);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("in_ready", {31'd0, bus_if.in_ready}, {31'd0, (q.size() < int'(DEPTH)) && !m_lock});
    @(posedge clk);
    model_step();
    #1;
    chk("cmd_valid",  {31'd0, bus_if.cmd_valid}, {31'd0, m_valid});
    chk("cmd",        {28'd0, bus_if.cmd},       {28'd0, m_cmd});
    chk("fifo_level", {28'd0, fifo_level},       q.size());
    chk("issued_cnt", {24'd0, issued_cnt},       m_issued);
    chk("seq_done",   {31'd0, seq_done},         {31'd0, m_seq});
    chk("err_cnt",    {28'd0, err_cnt},          m_err);
    ctrl_update();
  endtask

  task automatic do_reset();
    bus_if.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_cmd_valid",  {31'd0, bus_if.cmd_valid}, 0);
    chk("rst_cmd",        {28'd0, bus_if.cmd},       0);
    chk("rst_fifo_level", {28'd0, fifo_level},       0);
    chk("rst_issued_cnt", {24'd0, issued_cnt},       0);
    chk("rst_seq_done",   {31'd0, seq_done},         0);
    chk("rst_err_cnt",    {28'd0, err_cnt},          0);
    chk("rst_in_ready",   {31'd0, bus_if.in_ready},  1);
    model_reset();
    busy_force  = 1'b0;
    bus_if.busy = 1'b0;
    bus_if.done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_cmd   = 4'd0;
    bus_if.busy     = 1'b0;
    bus_if.done     = 1'b0;
    busy_force = 1'b0;
    busy_noise = 1'b0;
    done_noise = 1'b0;
    op_max     = 1;
    do_reset();

    // Pop gated while the controller loads its image
    busy_force  = 1'b1;
    bus_if.busy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus_if.in_valid = (i < 2);
      bus_if.in_cmd   = (i == 0) ? 4'd3 : 4'd5;
      tick();
    end
    bus_if.in_valid = 1'b0;
    busy_force  = 1'b0;
    bus_if.busy = 1'b0;
    repeat (10) tick();
    chk("gate_issued", {24'd0, issued_cnt}, 2);
    chk("gate_last_cmd", {28'd0, bus_if.cmd}, 5);

    // Two-cycle push-to-issue latency
    bus_if.in_valid = 1'b1;
    bus_if.in_cmd   = 4'd7;
    tick();
    bus_if.in_valid = 1'b0;
    chk("lat_early", {31'd0, bus_if.cmd_valid}, 0);
    tick();
    chk("lat_valid", {31'd0, bus_if.cmd_valid}, 1);
    chk("lat_cmd", {28'd0, bus_if.cmd}, 7);
    repeat (5) tick();

    // Fill past capacity while busy, then drain in order
    op_max      = 3;
    busy_force  = 1'b1;
    bus_if.busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_cmd   = 4'($urandom_range(1, 11));
      tick();
    end
    bus_if.in_valid = 1'b0;
    chk("full_level", {28'd0, fifo_level}, 8);
    chk("full_ready", {31'd0, bus_if.in_ready}, 0);
    busy_force  = 1'b0;
    bus_if.busy = 1'b0;
    repeat (60) tick();
    chk("full_drained", {28'd0, fifo_level}, 0);

    // Push and pop on the same edge
    busy_force  = 1'b1;
    bus_if.busy = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_cmd   = 4'd9;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    busy_force  = 1'b0;
    bus_if.busy = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_cmd   = 4'd10;
    tick();
    bus_if.in_valid = 1'b0;
    chk("simul_level", {28'd0, fifo_level}, 1);
    chk("simul_valid", {31'd0, bus_if.cmd_valid}, 1);
    chk("simul_cmd", {28'd0, bus_if.cmd}, 9);
    repeat (15) tick();

    // Random traffic with busy glitches and stray done pulses
    busy_noise = 1'b1;
    done_noise = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus_if.in_valid = 1'($urandom_range(0, 1));
      bus_if.in_cmd   = 4'($urandom_range(1, 15));
      tick();
    end
    bus_if.in_valid = 1'b0;
    busy_noise = 1'b0;
    done_noise = 1'b0;
    repeat (80) tick();
    chk("rand_drained", {28'd0, fifo_level}, 0);

    // Reset while waiting for busy to fall with three commands queued
    bus_if.in_valid = 1'b1;
    bus_if.in_cmd   = 4'd1;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    busy_force  = 1'b1;
    bus_if.busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_cmd   = 4'(i + 2);
      tick();
    end
    bus_if.in_valid = 1'b0;
    chk("pre_reset_level", {28'd0, fifo_level}, 3);
    do_reset();
    bus_if.in_valid = 1'b1;
    bus_if.in_cmd   = 4'd6;
    tick();
    bus_if.in_valid = 1'b0;
    tick();
    chk("post_reset_valid", {31'd0, bus_if.cmd_valid}, 1);
    chk("post_reset_cmd", {28'd0, bus_if.cmd}, 6);
    chk("post_reset_issued", {24'd0, issued_cnt}, 1);
    repeat (8) tick();

    // Illegal codes around a legal one
    do_reset();
    op_max = 1;
    for (int i = 0; i < 3; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_cmd   = (i == 0) ? 4'd12 : ((i == 1) ? 4'd4 : 4'd15);
      tick();
    end
    bus_if.in_valid = 1'b0;
    repeat (20) tick();
`ifdef CMD_FILTER_EN
    chk("filt_err", {28'd0, err_cnt}, 2);
    chk("filt_issued", {24'd0, issued_cnt}, 1);
`else
    chk("filt_err", {28'd0, err_cnt}, 0);
    chk("filt_issued", {24'd0, issued_cnt}, 3);
`endif

    // Issue counter saturation
    do_reset();
    op_max = 1;
    for (int i = 0; i < 900; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_cmd   = 4'($urandom_range(1, 11));
      tick();
    end
    bus_if.in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_issued", {24'd0, issued_cnt}, 255);

    // Write sequence: lock, wait for done, leave trailing entry queued
    do_reset();
    op_max = 1;
    for (int i = 0; i < 3; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_cmd   = (i == 0) ? 4'd1 : ((i == 1) ? 4'd0 : 4'd2);
      tick();
    end
    bus_if.in_valid = 1'b0;
    repeat (90) tick();
    chk("wr_seq_done", {31'd0, seq_done}, 1);
    chk("wr_level", {28'd0, fifo_level}, 1);
    chk("wr_ready", {31'd0, bus_if.in_ready}, 0);
    chk("wr_issued", {24'd0, issued_cnt}, 2);
    chk("wr_cmd", {28'd0, bus_if.cmd}, 0);
    bus_if.in_valid = 1'b1;
    bus_if.in_cmd   = 4'd3;
    repeat (5) tick();
    bus_if.in_valid = 1'b0;
    chk("fin_level", {28'd0, fifo_level}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
